// File: rtl/roberto_responde_if.sv
// roberto_responde_if: link-side bundle between the Roberto receiver unit,
// the UART RX/TX blocks and the board logic (byte in, response out, readings).
interface roberto_responde_if;
  logic        habilita;
  logic        pronto_rx;
  logic [7:0]  dado_rx;
  logic        pronto_tx;
  logic        partida_tx;
  logic [7:0]  dado_tx;
  logic [11:0] medida_1;
  logic [11:0] medida_2;
  logic        valido;
  logic        erro;
  logic        ocupado;
  logic [3:0]  db_estado;

  modport master (
    output habilita, pronto_rx, dado_rx, pronto_tx,
    input  partida_tx, dado_tx, medida_1, medida_2,
    input  valido, erro, ocupado, db_estado
  );

  modport slave (
    input  habilita, pronto_rx, dado_rx, pronto_tx,
    output partida_tx, dado_tx, medida_1, medida_2,
    output valido, erro, ocupado, db_estado
  );
endinterface

// File: rtl/roberto_responde.sv
// roberto_responde: collects an 8-byte "ddd#ddd#" frame, validates it,
// answers A/E + 1/2/? over TX, latches both readings as BCD.
// Ports: clock, reset (async, active-low), bus (slave): habilita,
// pronto_rx/dado_rx in, pronto_tx in, partida_tx/dado_tx out,
// medida_1/medida_2, valido, erro, ocupado, db_estado out.
module roberto_responde #(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input logic                clock,
  input logic                reset,
  roberto_responde_if.slave  bus
);
  localparam logic [3:0] S_INI = 4'd0;
  localparam logic [3:0] S_ESP = 4'd1;
  localparam logic [3:0] S_ARM = 4'd2;
  localparam logic [3:0] S_DEC = 4'd3;
  localparam logic [3:0] S_EN1 = 4'd4;
  localparam logic [3:0] S_TX1 = 4'd5;
  localparam logic [3:0] S_EN2 = 4'd6;
  localparam logic [3:0] S_TX2 = 4'd7;
  localparam logic [3:0] S_FIN = 4'd8;
  localparam logic [3:0] S_TMO = 4'd9;

  localparam int CW =
    (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(TIMEOUT_CICLOS - 1);

  logic [3:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rx_q [8];
  logic [7:0]    rx_d [8];
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    tx_q, tx_d;
  logic [11:0]   m1_q, m1_d;
  logic [11:0]   m2_q, m2_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic [11:0]   s1, s2;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // BCD digits compare correctly as plain binary.
  assign s1 = {rx_q[0][3:0], rx_q[1][3:0], rx_q[2][3:0]};
  assign s2 = {rx_q[4][3:0], rx_q[5][3:0], rx_q[6][3:0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    resp_d   = resp_q;
    tx_d     = tx_q;
    m1_d     = m1_q;
    m2_d     = m2_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    unique case (state_q)
      S_INI: begin
        if (bus.pronto_rx && bus.habilita) begin
          rx_d[0] = bus.dado_rx;
          state_d = S_ARM;
        end
      end
      S_ESP: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.pronto_rx) begin
          rx_d[idx_q] = bus.dado_rx;
          state_d     = S_ARM;
        end else if (cnt_d == CNT_FIM) begin
          // erro_q is then high for the single S_TMO cycle
          erro_d  = 1'b1;
          state_d = S_TMO;
        end
      end
      S_ARM: begin
        if (idx_q == 3'd3 || idx_q == 3'd7) begin
          if (rx_q[idx_q] != 8'h23) err_d = 1'b1;
        end else if (!eh_digito(rx_q[idx_q])) begin
          err_d = 1'b1;
        end
        idx_d   = idx_q + 3'd1;
        cnt_d   = '0;
        state_d = (idx_q == 3'd7) ? S_DEC : S_ESP;
      end
      S_DEC: begin
        if (err_q) begin
          tx_d   = 8'h45;
          resp_d = 8'h3F;
        end else begin
          tx_d   = 8'h41;
          resp_d = (s2 < s1) ? 8'h32 : 8'h31;
        end
        state_d = S_EN1;
      end
      S_EN1: state_d = S_TX1;
      S_TX1: begin
        if (bus.pronto_tx) begin
          tx_d    = resp_q;
          state_d = S_EN2;
        end
      end
      S_EN2: state_d = S_TX2;
      S_TX2: begin
        if (bus.pronto_tx) state_d = S_FIN;
      end
      S_FIN: begin
        if (err_q) begin
          erro_d = 1'b1;
        end else begin
          valido_d = 1'b1;
          m1_d     = s1;
          m2_d     = s2;
        end
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_INI;
      end
      S_TMO: begin
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_INI;
      end
      default: state_d = S_INI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_INI;
      idx_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rx_q     <= '{default: '0};
      resp_q   <= '0;
      tx_q     <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      resp_q   <= resp_d;
      tx_q     <= tx_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  assign bus.partida_tx = (state_q == S_EN1) || (state_q == S_EN2);
  assign bus.dado_tx    = tx_q;
  assign bus.medida_1   = m1_q;
  assign bus.medida_2   = m2_q;
  assign bus.valido     = valido_q;
  assign bus.erro       = erro_q;
  assign bus.ocupado    = (state_q != S_INI);
  assign bus.db_estado  = state_q;
endmodule

// File: tb/tb_roberto_responde.sv
// tb_roberto_responde: table vectors, corner sequences and random frames
// checked against a frame-level model of roberto_responde.
module tb_roberto_responde;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  roberto_responde_if bus();

  roberto_responde #(.TIMEOUT_CICLOS(100)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] frame;
    int          gap;
    int          tdly;
    bit          stray;
    logic [7:0]  tx1;
    logic [7:0]  tx2;
    logic [11:0] m1;
    logic [11:0] m2;
    bit          ok;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_valido = 0;
  int n_erro = 0;
  int tx_delay = 5;
  bit drop_hab = 0;
  logic [7:0] txq[$];
  logic [11:0] m1_exp = '0;
  logic [11:0] m2_exp = '0;
  vec_t tbl[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: TX bytes at each start pulse, result pulses.
  initial begin
    forever begin
      tick();
      if (bus.partida_tx) txq.push_back(bus.dado_tx);
      if (bus.valido) n_valido++;
      if (bus.erro) n_erro++;
    end
  end

  // Transmitter model: pronto_tx tx_delay cycles after each start.
  initial begin
    bus.pronto_tx = 1'b0;
    forever begin
      if (bus.partida_tx) begin
        repeat (tx_delay) tick();
        bus.pronto_tx = 1'b1;
        tick();
        bus.pronto_tx = 1'b0;
      end else begin
        tick();
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic vec_t model(input logic [63:0] f,
                                 input logic [11:0] pm1,
                                 input logic [11:0] pm2);
    vec_t r;
    int d[8];
    bit ok;
    int v1, v2;
    ok = 1;
    for (int i = 0; i < 8; i++) d[i] = int'(f[63-8*i -: 8]);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) ok = ok && (d[i] == 35);
      else ok = ok && (d[i] >= 48) && (d[i] <= 57);
    end
    r.frame = f; r.gap = 2; r.tdly = 4; r.stray = 0; r.ok = ok;
    if (ok) begin
      v1 = (d[0]-48)*100 + (d[1]-48)*10 + (d[2]-48);
      v2 = (d[4]-48)*100 + (d[5]-48)*10 + (d[6]-48);
      r.tx1 = "A";
      r.tx2 = (v2 < v1) ? "2" : "1";
      r.m1 = bcd(v1);
      r.m2 = bcd(v2);
    end else begin
      r.tx1 = "E";
      r.tx2 = "?";
      r.m1 = pm1;
      r.m2 = pm2;
    end
    return r;
  endfunction

  // Leaves the caller just after the edge that captured the last byte.
  task automatic send_bytes(input logic [63:0] f, input int gap,
                            input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap - 1) tick();
      if (drop_hab && i == 1) bus.habilita = 1'b0;
      bus.dado_rx = f[63-8*i -: 8];
      bus.pronto_rx = 1'b1;
      tick();
      bus.pronto_rx = 1'b0;
    end
  endtask

  task automatic wait_state(input logic [3:0] s);
    int k = 0;
    while (bus.db_estado != s && k < 200) begin
      tick();
      k++;
    end
    chk("reach_state", 32'(bus.db_estado), 32'(s));
  endtask

  task automatic do_frame(input vec_t v);
    int nv0, ne0, k;
    tx_delay = v.tdly;
    txq.delete();
    nv0 = n_valido;
    ne0 = n_erro;
    send_bytes(v.frame, v.gap, 8);
    bus.habilita = 1'b1;
    if (v.stray) begin
      wait_state(4'd5);
      bus.dado_rx = 8'h39;
      bus.pronto_rx = 1'b1;
      tick();
      bus.pronto_rx = 1'b0;
    end
    k = 0;
    while (bus.ocupado && k < 400) begin
      tick();
      k++;
    end
    chk("idle", 32'(bus.ocupado), 0);
    repeat (3) tick();
    chk("tx_count", txq.size(), 2);
    if (txq.size() >= 2) begin
      chk("tx_byte1", 32'(txq[0]), 32'(v.tx1));
      chk("tx_byte2", 32'(txq[1]), 32'(v.tx2));
    end
    chk("valido_pulses", n_valido - nv0, v.ok ? 1 : 0);
    chk("erro_pulses", n_erro - ne0, v.ok ? 0 : 1);
    chk("medida_1", 32'(bus.medida_1), 32'(v.m1));
    chk("medida_2", 32'(bus.medida_2), 32'(v.m2));
    m1_exp = v.m1;
    m2_exp = v.m2;
  endtask

  initial begin
    vec_t r;
    logic [63:0] f;
    int k, ne0, busy;

    tbl[0] = '{"123#456#", 3, 10, 0, 8'h41, 8'h31, 12'h123, 12'h456, 1};
    tbl[1] = '{"900#050#", 2, 5,  0, 8'h41, 8'h32, 12'h900, 12'h050, 1};
    tbl[2] = '{"777#777#", 4, 3,  0, 8'h41, 8'h31, 12'h777, 12'h777, 1};
    tbl[3] = '{"12A#456#", 3, 4,  0, 8'h45, 8'h3F, 12'h777, 12'h777, 0};
    tbl[4] = '{"123-456#", 2, 2,  0, 8'h45, 8'h3F, 12'h777, 12'h777, 0};
    tbl[5] = '{"000#999#", 2, 8,  1, 8'h41, 8'h31, 12'h000, 12'h999, 1};
    tbl[6] = '{"555#444#", 2, 6,  0, 8'h41, 8'h32, 12'h555, 12'h444, 1};
    tbl[7] = '{"1234567#", 2, 1,  0, 8'h45, 8'h3F, 12'h555, 12'h444, 0};

    bus.habilita = 1'b1;
    bus.pronto_rx = 1'b0;
    bus.dado_rx = '0;
    repeat (3) tick();
    chk("rst_partida", 32'(bus.partida_tx), 0);
    chk("rst_dado_tx", 32'(bus.dado_tx), 0);
    chk("rst_medidas", 32'({bus.medida_1, bus.medida_2}), 0);
    chk("rst_pulses", 32'({bus.valido, bus.erro, bus.ocupado}), 0);
    chk("rst_estado", 32'(bus.db_estado), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_frame(tbl[i]);

    // Timeout after three bytes.
    tx_delay = 5;
    txq.delete();
    ne0 = n_erro;
    send_bytes("321#", 3, 3);
    k = 0;
    while (!bus.erro && k < 300) begin
      tick();
      k++;
    end
    chk("timeout_cycles", k, 100);
    repeat (3) tick();
    chk("timeout_no_tx", txq.size(), 0);
    chk("timeout_erro_pulses", n_erro - ne0, 1);
    chk("timeout_idle", 32'(bus.ocupado), 0);
    chk("timeout_medida_1", 32'(bus.medida_1), 32'(m1_exp));
    do_frame(model("321#654#", m1_exp, m2_exp));

    // habilita low: bytes ignored.
    bus.habilita = 1'b0;
    txq.delete();
    busy = 0;
    f = "246#802#";
    for (int i = 0; i < 8; i++) begin
      bus.dado_rx = f[63-8*i -: 8];
      bus.pronto_rx = 1'b1;
      tick();
      bus.pronto_rx = 1'b0;
      if (bus.ocupado) busy++;
      tick();
      if (bus.ocupado) busy++;
    end
    chk("hab0_busy_cycles", busy, 0);
    chk("hab0_no_tx", txq.size(), 0);
    bus.habilita = 1'b1;
    do_frame(model("246#802#", m1_exp, m2_exp));

    // Reset while waiting for the first TX byte to finish.
    tx_delay = 30;
    txq.delete();
    send_bytes("246#135#", 2, 8);
    wait_state(4'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_partida", 32'(bus.partida_tx), 0);
    chk("midrst_dado_tx", 32'(bus.dado_tx), 0);
    chk("midrst_medidas", 32'({bus.medida_1, bus.medida_2}), 0);
    chk("midrst_state", 32'({bus.ocupado, bus.db_estado}), 0);
    m1_exp = '0;
    m2_exp = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    do_frame(model("246#135#", m1_exp, m2_exp));

    // Random frames, some corrupted, some dropping habilita mid-frame.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 3 || i == 7) f[63-8*i -: 8] = 8'h23;
        else f[63-8*i -: 8] = 8'(8'h30 + $urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0)
        f[63-8*$urandom_range(0, 7) -: 8] = 8'($urandom_range(0, 255));
      r = model(f, m1_exp, m2_exp);
      r.gap = $urandom_range(2, 4);
      r.tdly = $urandom_range(1, 8);
      drop_hab = ($urandom_range(0, 2) == 0);
      do_frame(r);
      drop_hab = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
